// File: rtl/ram_arbiter_4.sv
// rtl/ram_arbiter_4.sv - four-requester round-robin arbiter for a single-port RAM
// Clears the whole RAM after reset, then grants one command per cycle.
module ram_arbiter_4 #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req_valid,
  input  logic [3:0]      req_we,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic [3:0]      req_ready,
  output logic            rsp_valid,
  output logic [1:0]      rsp_id,
  output logic [DW-1:0]   rsp_rdata,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout,
  output logic            init_busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_id_q, rsp_id_d;

  logic          gnt_any;
  logic [1:0]    gnt_idx;
  logic [1:0]    cand;

  // Search starts just after the last granted index so it ends up lowest priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    req_ready   = 4'b0000;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = cnt_q;
    ram_din     = '0;
    if (state_q == ST_INIT) begin
      // Gating by rst keeps the RAM quiet while reset is held.
      ram_en = ~rst;
      ram_we = ~rst;
      cnt_d  = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = ST_RUN;
      end
    end else if (gnt_any) begin
      ram_en             = 1'b1;
      ram_we             = req_we[gnt_idx];
      ram_addr           = req_addr[int'(gnt_idx)*AW +: AW];
      ram_din            = req_wdata[int'(gnt_idx)*DW +: DW];
      req_ready[gnt_idx] = 1'b1;
      ptr_d              = gnt_idx;
      if (!req_we[gnt_idx]) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = ram_dout;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: doc/ram_arbiter_4.md
RAM_ARBITER_4 -- requirements
Module: ram_arbiter_4

Interface
REQ-001 SHALL have parameter AW, default 10, RAM address width (depth 2^AW words).
REQ-002 SHALL have parameter DW, default 16, RAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  4  per-requester command valid; bit i = requester i.
REQ-006 SHALL have port req_we  input  4  per-requester write enable (1 write, 0 read).
REQ-007 SHALL have port req_addr  input  4*AW  requester i address at bits [AW*i+AW-1:AW*i].
REQ-008 SHALL have port req_wdata  input  4*DW  requester i write data at bits [DW*i+DW-1:DW*i].
REQ-009 SHALL have port req_ready  output  4  one-hot or zero grant; command i transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port rsp_valid  output  1  read data valid.
REQ-011 SHALL have port rsp_id  output  2  requester index owning rsp_rdata.
REQ-012 SHALL have port rsp_rdata  output  DW  read data.
REQ-013 SHALL have port ram_en  output  1  RAM port enable.
REQ-014 SHALL have port ram_we  output  1  RAM port write enable.
REQ-015 SHALL have port ram_addr  output  AW  RAM port address.
REQ-016 SHALL have port ram_din  output  DW  RAM port write data.
REQ-017 SHALL have port ram_dout  input  DW  RAM port read data, registered in RAM, valid one cycle after ram_en.
REQ-018 SHALL have port init_busy  output  1  high while the clear sweep runs.

Function
REQ-019 SHALL implement two states: INIT (clear sweep) and RUN (arbitration).
REQ-020 INIT: one write per cycle, ram_en=1, ram_we=1, ram_din=0, ram_addr=sweep counter, counter 0 to 2^AW-1 ascending.
REQ-021 INIT: req_ready=0, init_busy=1; after the write to address 2^AW-1 the state SHALL become RUN on that same edge (INIT lasts exactly 2^AW cycles after reset release).
REQ-022 RUN: init_busy=0; when any req_valid bit is high exactly one requester SHALL be granted per cycle, combinationally from req_valid and the priority pointer.
REQ-023 Round-robin: with pointer p (last granted index), priority order SHALL be p+1, p+2, p+3, p (mod 4); on a transfer p SHALL update to the granted index; with no transfer p SHALL hold.
REQ-024 Granted requester g: ram_en=1, ram_we=req_we[g], ram_addr and ram_din from slice g, req_ready[g]=1, all other ready bits 0.
REQ-025 No valid request in RUN: ram_en=0, ram_we=0, req_ready=0; ram_addr and ram_din values are don't-care.
REQ-026 Granted read SHALL give rsp_valid=1 and rsp_id=g in the following cycle, with rsp_rdata=ram_dout passed through combinationally; latency exactly 1 cycle, one response per read, responses in grant order.
REQ-027 Writes SHALL produce no response.
REQ-028 Back-to-back reads SHALL give rsp_valid high on consecutive cycles with no bubble.
REQ-029 Requesters SHALL NOT make req_valid depend on req_ready; a valid command SHALL hold stable until its transfer.
REQ-030 Idle requesters SHALL NOT be granted; a continuously valid requester SHALL be granted within 4 cycles.

Reset
REQ-031 While rst is high: state=INIT, sweep counter=0, p=3 (requester 0 first), rsp_valid=0, rsp_id=0, req_ready=0, ram_en=0, ram_we=0, init_busy=1.
REQ-032 rst asserted mid-INIT or mid-RUN SHALL take effect immediately without a clock edge and SHALL discard any pending read response.
REQ-033 After release, a full 2^AW-cycle sweep SHALL restart from address 0.

Verification
REQ-034 Release rst -> 1024 cycles ram_en=ram_we=1, ram_addr 0..1023, ram_din=0x0000; init_busy falls after cycle 1024; a later read of 0x3FF returns 0x0000.
REQ-035 Requester 2 writes 0xBEEF to 0x155, then reads 0x155 -> next cycle rsp_valid=1, rsp_id=2, rsp_rdata=0xBEEF.
REQ-036 All four valid continuously from first RUN cycle -> grant order 0,1,2,3,0,1 with one transfer per cycle.
REQ-037 Only requesters 1 and 3 valid, last grant 1 -> grant 3, then 1, then 3; requesters 0 and 2 never granted.
REQ-038 rst pulsed when the sweep reaches address 500 -> ram_en=0 and rsp_valid=0 immediately; after release the sweep restarts at 0 and runs 1024 cycles.
REQ-039 Requesters 0 and 1 read 0x010 and 0x020 (holding 0x1111 and 0x2222) in the same cycle -> rsp on consecutive cycles: id0/0x1111, then id1/0x2222.
